// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  // Index width for a file of n entries.
  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback,
// flushed on soft clear. Entry 0 never reports busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NREAD = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             set_en,
  input  logic [$clog2(NREGS)-1:0]         set_idx,
  input  logic                             clr_en,
  input  logic [$clog2(NREGS)-1:0]         clr_idx,
  input  logic [NREAD*$clog2(NREGS)-1:0]   lookup_idx,
  output logic [NREAD-1:0]                 lookup_busy
);

  localparam int AW = rf_aw(NREGS);

  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] busy_q;

  // Next busy vector: clear first so a same-cycle set (newer producer) wins; flush overrides all.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
    if (flush)  busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy bits register with asynchronous reset to all-idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_lookup
    assign lookup_busy[i] = busy_q[lookup_idx[i*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with optional write-to-read bypass, busy-bit
// scoreboard and a zeroing sweep after reset / soft clear (array itself has no reset).
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int NREGS   = NREGS_DEFAULT,
  parameter int NREAD   = 2,
  parameter bit BYPASS  = 1'b1,
  parameter int DBG_REG = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  output logic                           ready,
  input  logic                           we,
  input  logic [$clog2(NREGS)-1:0]       waddr,
  input  logic [XLEN-1:0]                wdata,
  input  logic [NREAD*$clog2(NREGS)-1:0] raddr,
  output logic [NREAD*XLEN-1:0]          rdata,
  output logic [NREAD-1:0]               rbusy,
  input  logic                           issue_valid,
  input  logic [$clog2(NREGS)-1:0]       issue_rd,
  output logic [XLEN-1:0]                dbg_out
);

  localparam int            AW       = rf_aw(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] DBG_IDX  = AW'(DBG_REG);

  rf_state_e     state_d, state_q;
  logic [AW-1:0] cnt_d, cnt_q;
  logic          ready_d, ready_q;

  logic [XLEN-1:0] mem_q [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;

  logic            wr_ok;
  logic            sb_set;
  logic            sb_flush;
  logic [NREAD-1:0] sb_busy;

  // Architectural write / issue only take effect in RUN and never in a clear cycle.
  assign wr_ok    = ready_q && we && (waddr != '0) && !clr;
  assign sb_set   = ready_q && issue_valid && (issue_rd != '0) && !clr;
  assign sb_flush = ready_q && clr;

  // Sweep sequencing: INIT walks cnt over every entry, RUN waits for a soft clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RF_RUN: begin
        if (clr) begin
          state_d = RF_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RF_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == RF_RUN);
  end

  // Control state with asynchronous reset back to the start of the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Single array write port shared between the zeroing sweep and writeback.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = wdata;
    if (!ready_q) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Register array storage; contents become defined through the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NREAD (NREAD)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .flush       (sb_flush),
    .set_en      (sb_set),
    .set_idx     (issue_rd),
    .clr_en      (wr_ok),
    .clr_idx     (waddr),
    .lookup_idx  (raddr),
    .lookup_busy (sb_busy)
  );

  // Per-port read mux: zero register, same-cycle bypass, then array; all gated by ready.
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr[i*AW +: AW];
    assign hit = BYPASS && we && (waddr == ra);
    assign rdata[i*XLEN +: XLEN] = (!ready_q || ra == '0) ? '0 : (hit ? wdata : mem_q[ra]);
    assign rbusy[i] = ready_q && sb_busy[i] && !hit;
  end

  assign ready   = ready_q;
  assign dbg_out = (!ready_q || DBG_REG == 0) ? '0 : mem_q[DBG_IDX];

endmodule
